// File: rtl/bus_cpu_datapath.sv
// Single-bus CPU datapath: register file slice, MDR, bus encoder/multiplexer and ALU,
// sequenced one clock at a time by external control strobes.

module bus_cpu_datapath_mdr #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             MDRin,
    input  logic             Read,
    input  logic [WIDTH-1:0] bus_data,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] MDRout
);
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            MDRout <= '0;
        else if (MDRin)
            MDRout <= Read ? Mdatain : bus_data;
    end
endmodule

module bus_cpu_datapath_encoder (
    input  logic [31:0] encoderInput,
    output logic [4:0]  encoderOutput
);
    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        encoderOutput = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (encoderInput[i])
                encoderOutput = 5'(i);
        end
    end
endmodule

module bus_cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHighout,
    input  logic             Zlowout,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             InPortout,
    input  logic             Cout,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R7in,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             Yin,
    input  logic             Zin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             AND,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [4:0]       operation,
    output logic [31:0]      encoder_input
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [WIDTH-1:0]   bus_data;
    logic [WIDTH-1:0]   R3_data_out, R4_data_out, R7_data_out;
    logic [WIDTH-1:0]   PC_data_out, IR_data_out, MAR_data_out, Y_data_out;
    logic [WIDTH-1:0]   ZHigh_data_out, ZLow_data_out, MDR_data_out;
    logic [WIDTH-1:0]   C_sign_extended, InPort_data_out;
    logic [2*WIDTH-1:0] c_data_out;
    logic [4:0]         encoder_output;

    assign C_sign_extended = {{(WIDTH-19){IR_data_out[18]}}, IR_data_out[18:0]};
    assign InPort_data_out = '0;

    assign encoder_input = {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, ZHighout,
                            LOout, HIout, R15out, R14out, R13out, R12out, R11out,
                            R10out, R9out, R8out, R7out, R6out, R5out, R4out,
                            R3out, R2out, R1out, R0out};

    bus_cpu_datapath_encoder bus_encoder (
        .encoderInput  (encoder_input),
        .encoderOutput (encoder_output)
    );

    bus_cpu_datapath_mdr #(.WIDTH(WIDTH)) mdr_unit (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .MDRin    (MDRin),
        .Read     (Read),
        .bus_data (bus_data),
        .Mdatain  (Mdatain),
        .MDRout   (MDR_data_out)
    );

    // R0-R2, R5-R6, R8-R15, HI and LO have no load path and read as zero.
    always_comb begin
        bus_data = '0;
        case (encoder_output)
            5'd3:    bus_data = R3_data_out;
            5'd4:    bus_data = R4_data_out;
            5'd7:    bus_data = R7_data_out;
            5'd18:   bus_data = ZHigh_data_out;
            5'd19:   bus_data = ZLow_data_out;
            5'd20:   bus_data = PC_data_out;
            5'd21:   bus_data = MDR_data_out;
            5'd22:   bus_data = InPort_data_out;
            5'd23:   bus_data = C_sign_extended;
            default: bus_data = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            R3_data_out    <= '0;
            R4_data_out    <= '0;
            R7_data_out    <= '0;
            PC_data_out    <= '0;
            IR_data_out    <= '0;
            MAR_data_out   <= '0;
            Y_data_out     <= '0;
            ZHigh_data_out <= '0;
            ZLow_data_out  <= '0;
        end else begin
            if (R3in)  R3_data_out  <= bus_data;
            if (R4in)  R4_data_out  <= bus_data;
            if (R7in)  R7_data_out  <= bus_data;
            if (PCin)  PC_data_out  <= bus_data;
            if (IRin)  IR_data_out  <= bus_data;
            if (MARin) MAR_data_out <= bus_data;
            if (Yin)   Y_data_out   <= bus_data;
            if (Zin) begin
                ZHigh_data_out <= c_data_out[2*WIDTH-1:WIDTH];
                ZLow_data_out  <= c_data_out[WIDTH-1:0];
            end
        end
    end

    logic [WIDTH-1:0]          alu_a, alu_b, div_b;
    logic [4:0]                shamt;
    logic [2*WIDTH-1:0]        ror_wide, rol_wide;
    logic signed [2*WIDTH-1:0] mul_a, mul_b, mul_p;
    logic signed [WIDTH-1:0]   div_q, div_r;

    assign alu_a    = Y_data_out;
    assign alu_b    = bus_data;
    assign shamt    = alu_b[4:0];
    assign ror_wide = {alu_a, alu_a} >> shamt;
    assign rol_wide = {alu_a, alu_a} << shamt;
    assign mul_a    = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
    assign mul_b    = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    assign mul_p    = mul_a * mul_b;
    // Substitute a divisor of 1 so the divider never sees zero; the result is masked below.
    assign div_b    = (alu_b == '0) ? WIDTH'(1) : alu_b;
    assign div_q    = $signed(alu_a) / $signed(div_b);
    assign div_r    = $signed(alu_a) % $signed(div_b);

    always_comb begin
        c_data_out = {{WIDTH{1'b0}}, alu_b};
        if (IncPC) begin
            c_data_out = {{WIDTH{1'b0}}, alu_b + WIDTH'(1)};
        end else begin
            case (operation)
                OP_ADD:  c_data_out = {{WIDTH{1'b0}}, alu_a + alu_b};
                OP_SUB:  c_data_out = {{WIDTH{1'b0}}, alu_a - alu_b};
                OP_AND:  c_data_out = {{WIDTH{1'b0}}, alu_a & alu_b};
                OP_OR:   c_data_out = {{WIDTH{1'b0}}, alu_a | alu_b};
                OP_ROR:  c_data_out = {{WIDTH{1'b0}}, ror_wide[WIDTH-1:0]};
                OP_ROL:  c_data_out = {{WIDTH{1'b0}}, rol_wide[2*WIDTH-1:WIDTH]};
                OP_SHR:  c_data_out = {{WIDTH{1'b0}}, alu_a >> shamt};
                OP_SHRA: c_data_out = {{WIDTH{1'b0}}, $signed(alu_a) >>> shamt};
                OP_SHL:  c_data_out = {{WIDTH{1'b0}}, alu_a << shamt};
                OP_MUL:  c_data_out = mul_p;
                OP_DIV:  c_data_out = (alu_b == '0) ? '0 : {div_r, div_q};
                OP_NEG:  c_data_out = {{WIDTH{1'b0}}, -alu_b};
                OP_NOT:  c_data_out = {{WIDTH{1'b0}}, ~alu_b};
                default: c_data_out = {{WIDTH{1'b0}}, alu_b};
            endcase
        end
    end

    // AND strobe and MAR contents are not consumed anywhere yet.
    logic unused_sink;
    assign unused_sink = ^{AND, MAR_data_out, IR_data_out[WIDTH-1:19]};
endmodule

// File: tb/tb_bus_cpu_datapath.sv
// Self-checking bench for bus_cpu_datapath: directed datapath sequences plus random ALU
// operations and random bus-source selections compared against a behavioural model.

module tb_bus_cpu_datapath;
    logic        Clock, Resetn;
    logic [23:0] sel;
    logic        R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin;
    logic        IncPC, Read, AND;
    logic [31:0] Mdatain;
    logic [4:0]  operation;
    logic [31:0] encoder_input;

    bus_cpu_datapath dut (
        .Clock(Clock), .Resetn(Resetn),
        .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
        .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
        .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
        .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
        .HIout(sel[16]), .LOout(sel[17]), .ZHighout(sel[18]), .Zlowout(sel[19]),
        .PCout(sel[20]), .MDRout(sel[21]), .InPortout(sel[22]), .Cout(sel[23]),
        .R3in(R3in), .R4in(R4in), .R7in(R7in), .PCin(PCin), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .IncPC(IncPC), .Read(Read), .AND(AND),
        .Mdatain(Mdatain), .operation(operation),
        .encoder_input(encoder_input)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    // Model of register contents as the bench has loaded them.
    logic [31:0] m_r3, m_r4, m_r7, m_pc, m_ir, m_mdr, m_y;
    logic [63:0] m_z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic inc,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint sa, sb, p, q, rm;
        int n;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        n  = int'(b % 32);
        r  = b;
        if (inc) return {32'b0, b + 32'd1};
        case (op)
            5'd3:  r = a + b;
            5'd4:  r = a - b;
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  begin r = a; repeat (n) r = {r[0], r[31:1]}; end
            5'd8:  begin r = a; repeat (n) r = {r[30:0], r[31]}; end
            5'd9:  begin r = a; repeat (n) r = {1'b0, r[31:1]}; end
            5'd10: begin r = a; repeat (n) r = {r[31], r[31:1]}; end
            5'd11: begin r = a; repeat (n) r = {r[30:0], 1'b0}; end
            5'd15: begin p = sa * sb; return p; end
            5'd16: begin
                if (b == 0) return 64'd0;
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            5'd17: r = 32'd0 - b;
            5'd18: r = ~b;
            default: r = b;
        endcase
        return {32'b0, r};
    endfunction

    function automatic logic [31:0] ref_bus(input logic [23:0] s);
        int idx;
        idx = -1;
        for (int i = 0; i < 24; i++) if (s[i]) idx = i;
        case (idx)
            3:  return m_r3;
            4:  return m_r4;
            7:  return m_r7;
            18: return m_z[63:32];
            19: return m_z[31:0];
            20: return m_pc;
            21: return m_mdr;
            23: return {{13{m_ir[18]}}, m_ir[18:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] ref_enc(input logic [23:0] s);
        logic [4:0] idx;
        idx = 5'd31;
        for (int i = 0; i < 24; i++) if (s[i]) idx = 5'(i);
        return idx;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_ctrl();
        sel = '0;
        {R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin} = '0;
        IncPC = 0; Read = 0; AND = 0;
        operation = 5'd0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clear_ctrl();
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
        m_mdr = v;
        clear_ctrl();
    endtask

    // dst: 0=Y 1=R3 2=R7 3=PC 4=IR
    task automatic mdr_to(input int dst);
        clear_ctrl();
        sel[21] = 1;
        case (dst)
            0: Yin = 1;
            1: R3in = 1;
            2: R7in = 1;
            3: PCin = 1;
            default: IRin = 1;
        endcase
        tick();
        case (dst)
            0: m_y = m_mdr;
            1: m_r3 = m_mdr;
            2: m_r7 = m_mdr;
            3: m_pc = m_mdr;
            default: m_ir = m_mdr;
        endcase
        clear_ctrl();
    endtask

    task automatic run_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic inc);
        logic [63:0] e;
        load_mdr(a);
        mdr_to(0);
        load_mdr(b);
        sel[21] = 1; operation = op; IncPC = inc; Zin = 1;
        #1;
        e = ref_alu(op, inc, a, b);
        check($sformatf("c op=%0d inc=%0d", op, inc), dut.c_data_out, e);
        exp_q.push_back(e);
        tick();
        clear_ctrl();
        m_z = exp_q.pop_front();
        check($sformatf("z op=%0d inc=%0d", op, inc),
              {dut.ZHigh_data_out, dut.ZLow_data_out}, m_z);
    endtask

    initial begin
        logic [4:0]  ops[15];
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd31};
        clear_ctrl();
        Mdatain = '0;
        {m_r3, m_r4, m_r7, m_pc, m_ir, m_mdr, m_y} = '0;
        m_z = '0;
        Resetn = 0;
        #12;
        check("reset r3", {32'b0, dut.R3_data_out}, 64'd0);
        check("reset z", {dut.ZHigh_data_out, dut.ZLow_data_out}, 64'd0);
        check("reset mdr", {32'b0, dut.mdr_unit.MDRout}, 64'd0);
        check("reset enc", {32'b0, encoder_input}, 64'd0);
        check("reset bus", {32'b0, dut.bus_data}, 64'd0);
        @(negedge Clock);
        Resetn = 1;
        tick();

        // Load path: memory -> MDR -> R3
        load_mdr(32'hFFFFFFDE);
        sel[21] = 1; R3in = 1;
        #1;
        check("enc mdrout", {32'b0, encoder_input}, 64'h00200000);
        check("enc idx mdr", {59'b0, dut.bus_encoder.encoderOutput}, 64'd21);
        tick();
        m_r3 = m_mdr;
        clear_ctrl();
        check("r3 load", {32'b0, dut.R3_data_out}, 64'hFFFFFFDE);

        // SHRA via R3/R7 -> Y/bus -> Z -> R4
        load_mdr(32'h24);
        mdr_to(2);
        sel[3] = 1; Yin = 1; tick(); m_y = m_r3; clear_ctrl();
        sel[7] = 1; operation = 5'b01010; Zin = 1; tick(); clear_ctrl();
        sel[19] = 1; R4in = 1; tick(); clear_ctrl();
        m_r4 = 32'hFFFFFFFD;
        m_z  = 64'hFFFFFFFD;
        check("shra r4", {32'b0, dut.R4_data_out}, 64'hFFFFFFFD);
        check("shra zhigh", {32'b0, dut.ZHigh_data_out}, 64'd0);

        // Shift by zero and logical vs arithmetic shift
        run_alu(32'h80000000, 32'h20, 5'b01010, 0);
        check("shra by0", {32'b0, dut.ZLow_data_out}, 64'h80000000);
        run_alu(32'h80000000, 32'h1, 5'b01010, 0);
        check("shra by1", {32'b0, dut.ZLow_data_out}, 64'hC0000000);
        run_alu(32'h80000000, 32'h1, 5'b01001, 0);
        check("shr by1", {32'b0, dut.ZLow_data_out}, 64'h40000000);

        // IncPC and bus priority
        load_mdr(32'd5);
        mdr_to(3);
        sel[20] = 1; IncPC = 1; operation = 5'b00100; Zin = 1; tick(); clear_ctrl();
        m_z = 64'd6;
        check("incpc zlow", {32'b0, dut.ZLow_data_out}, 64'd6);
        load_mdr(32'hABCD1234);
        sel[20] = 1; sel[21] = 1;
        #1;
        check("prio pc+mdr", {32'b0, dut.bus_data}, 64'hABCD1234);
        clear_ctrl();

        // MUL / DIV signed corners
        run_alu(32'hFFFFFFF9, 32'd2, 5'b01111, 0);
        check("mul -7*2", {dut.ZHigh_data_out, dut.ZLow_data_out}, 64'hFFFFFFFF_FFFFFFF2);
        run_alu(32'hFFFFFFF9, 32'd2, 5'b10000, 0);
        check("div -7/2", {dut.ZHigh_data_out, dut.ZLow_data_out}, 64'hFFFFFFFF_FFFFFFFD);
        run_alu(32'hFFFFFFF9, 32'd0, 5'b10000, 0);
        check("div by0", {dut.ZHigh_data_out, dut.ZLow_data_out}, 64'd0);

        // C source: sign-extended IR[18:0]
        load_mdr(32'h1234_5678 | 32'h0004_0000);
        mdr_to(4);
        sel[23] = 1;
        #1;
        check("cout sext", {32'b0, dut.bus_data}, {32'b0, 32'hFFFC_5678 | 32'h0});
        clear_ctrl();

        // Enable toggled away before the edge has no effect
        load_mdr(32'h5555AAAA);
        sel[21] = 1; Yin = 1;
        #2;
        Yin = 0;
        tick();
        clear_ctrl();
        check("yin glitch", {32'b0, dut.Y_data_out}, {32'b0, m_y});

        // Random ALU operations
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rop = ops[$urandom_range(0, 14)];
            if (rop == 5'd16 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            run_alu(ra, rb, rop, ($urandom_range(0, 7) == 0));
        end

        // Random bus-source selections (single and multiple)
        for (int i = 0; i < 30; i++) begin
            clear_ctrl();
            if ($urandom_range(0, 1) == 0) sel = 24'($urandom);
            else sel[$urandom_range(0, 23)] = 1'b1;
            #1;
            check("enc vec", {32'b0, encoder_input}, {40'b0, sel});
            check("enc idx", {59'b0, dut.bus_encoder.encoderOutput}, {59'b0, ref_enc(sel)});
            check("bus rand", {32'b0, dut.bus_data}, {32'b0, ref_bus(sel)});
            #1;
        end
        clear_ctrl();

        // Asynchronous reset mid-cycle with a load enable active
        @(negedge Clock);
        sel[3] = 1; R3in = 1;
        #1;
        Resetn = 0;
        #1;
        check("arst r3", {32'b0, dut.R3_data_out}, 64'd0);
        check("arst z", {dut.ZHigh_data_out, dut.ZLow_data_out}, 64'd0);
        check("arst pc", {32'b0, dut.PC_data_out}, 64'd0);
        check("arst mdr", {32'b0, dut.mdr_unit.MDRout}, 64'd0);
        check("arst bus", {32'b0, dut.bus_data}, 64'd0);
        clear_ctrl();
        sel[21] = 1; R3in = 1;
        tick();
        check("arst hold r3", {32'b0, dut.R3_data_out}, 64'd0);
        clear_ctrl();
        #1;
        check("arst enc", {32'b0, encoder_input}, 64'd0);
        Resetn = 1;
        tick();

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_cpu_datapath.md
Name: bus_cpu_datapath

Overview:
- Single-bus CPU datapath: general registers R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z (ZHigh/ZLow), HI, LO, C-sign-extend and InPort sources, a 32-to-5 bus encoder/multiplexer and a 5-bit-opcode ALU.
- Driven cycle-by-cycle by external control strobes (future control unit, currently the bench).
- Internal nodes exist under fixed names so benches can probe them hierarchically.

Parameters:
- WIDTH, 32, data-path word width; Z is 2*WIDTH.

Ports:
- Clock  in  1  system clock; all registers load on rising edge.
- Resetn  in  1  asynchronous, active-low reset of every register.
- R0out..R15out, HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout  in  1 each  bus-source selects.
- R3in, R4in, R7in, PCin, IRin, MARin, MDRin, Yin, Zin  in  1 each  register load enables.
- IncPC  in  1  ALU computes bus+1 instead of `operation`.
- Read  in  1  MDR input mux: 1 selects Mdatain, 0 selects bus.
- AND  in  1  legacy strobe; accepted, no functional effect.
- Mdatain  in  32  memory read data.
- operation  in  5  ALU opcode.
- encoder_input  out  32  one-hot vector of bus-source selects, combinational.

Behaviour:
- Required internal names: bus_data; instances mdr_unit (output MDRout) and bus_encoder (signals encoderInput, encoderOutput); R3_data_out, R4_data_out, R7_data_out, IR_data_out, Y_data_out, PC_data_out, ZLow_data_out, ZHigh_data_out, c_data_out (64-bit ALU result).
- Reset (Resetn=0, any time, asynchronous): every register = 0; dominates any load enable.
- encoder_input bit map:
  - bits 0–15: R0out..R15out
  - 16 HIout, 17 LOout, 18 ZHighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 InPortout, 23 Cout
  - bits 24–31: 0
- Encoder output = index of highest set bit; 5'd31 if none.
- Bus mux:
  - bus = selected source register.
  - No source selected → bus = 0.
  - Multiple sources → highest index wins (e.g. PCout+MDRout → MDR).
- C source = sign-extended IR[18:0]. InPort register has no load path; holds 0.
- Registers without in-ports (R0–R2, R5–R6, R8–R15, HI, LO) stay 0.
- Register loads: on rising Clock with enable high, register ← bus (MDR ← Read?Mdatain:bus). Enable sampled only at the edge; mid-cycle toggles have no effect.
- ALU (combinational):
  - A = Y, B = bus; c_data_out 64-bit.
  - Z ← c_data_out when Zin; ZHigh = c[63:32], ZLow = c[31:0].
  - IncPC=1: c = {32'b0, B+1}, overrides operation.
- Opcodes; non-MUL/DIV results zero-extend to 64 bits:
  - 00011 ADD A+B (wraps mod 2^32)
  - 00100 SUB A−B
  - 00101 AND
  - 00110 OR
  - 00111 ROR A by B[4:0]
  - 01000 ROL
  - 01001 SHR logical
  - 01010 SHRA arithmetic (sign-filled)
  - 01011 SHL
  - 01111 MUL signed 64-bit product
  - 10000 DIV signed: ZLow = quotient, ZHigh = remainder; divisor 0 → both 0
  - 10001 NEG −B
  - 10010 NOT ~B
  - other codes → c = {32'b0, B}
- Shift amount = B[4:0]; shift by 0 returns A unchanged.
- Latency: source → bus → ALU → c_data_out combinational; register visible one edge after load.

Test Plan:
- Reset: drive Resetn=0 mid-cycle with R3in=1 → all registers 0 immediately, encoder_input=0, bus=0.
- Load path: Mdatain=0xFFFFFFDE, Read=1, MDRin=1 at edge; then MDRout=1, R3in=1 at next edge → R3=0xFFFFFFDE, encoder_input=0x00200000.
- SHRA: R3=0xFFFFFFDE, R7=0x24; R3out+Yin edge; R7out, operation=01010, Zin edge; Zlowout+R4in edge → R4=0xFFFFFFFD, ZHigh=0.
- Shift by 0 and logical/arith contrast: Y=0x80000000, B=0x20 → SHRA gives 0x80000000; B=1 → SHRA 0xC0000000, SHR 0x40000000.
- IncPC/priority: PC=5, PCout+IncPC+Zin edge → ZLow=6. PCout and MDRout together → bus = MDR contents.
- MUL/DIV: Y=−7, B=2 → MUL c=0xFFFFFFFF_FFFFFFF2; DIV ZLow=0xFFFFFFFD (−3), ZHigh=0xFFFFFFFF (−1); B=0 → Z=0.
